// File: rtl/mul_long_unit.sv
// Iterative radix-2 multiplier for MUL/MLA/UMULL/SMULL/UMLAL/SMLAL.
// Optional feature macro: MUL_EARLY_TERM_EN (stop iterating once the multiplier is empty).
module mul_long_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic             is_signed,
    input  logic             accumulate,
    input  logic             long,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             long_out,
    output logic             flag_n,
    output logic             flag_z,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic               acc_en_q, acc_en_d;
    logic               long_q, long_d;
    logic [WIDTH-1:0]   result_lo_q, result_lo_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic               long_out_q, long_out_d;
    logic               flag_n_q, flag_n_d;
    logic               flag_z_q, flag_z_d;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] fix_signed;
    logic [2*WIDTH-1:0] fix_sum;
    logic               early_stop;

    // Magnitudes: -2^(W-1) negates to itself, which is its correct unsigned magnitude.
    assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    assign fix_signed = neg_q ? (~prod_q + 1'b1) : prod_q;
    assign fix_sum    = fix_signed + (acc_en_q ? {acc_hi_q, acc_lo_q} : {(2*WIDTH){1'b0}});

`ifdef MUL_EARLY_TERM_EN
    assign early_stop = (mplier_q == '0);
`else
    assign early_stop = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        acc_lo_d    = acc_lo_q;
        acc_hi_d    = acc_hi_q;
        acc_en_d    = acc_en_q;
        long_d      = long_q;
        result_lo_d = result_lo_q;
        result_hi_d = result_hi_q;
        long_out_d  = long_out_q;
        flag_n_d    = flag_n_q;
        flag_z_d    = flag_z_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d     = {{WIDTH{1'b0}}, a_mag};
                    mplier_d    = b_mag;
                    neg_d       = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    prod_d      = '0;
                    cnt_d       = '0;
                    acc_lo_d    = acc_lo;
                    acc_hi_d    = acc_hi & {WIDTH{long}};
                    acc_en_d    = accumulate;
                    long_d      = long;
                    result_lo_d = '0;
                    result_hi_d = '0;
                    long_out_d  = 1'b0;
                    flag_n_d    = 1'b0;
                    flag_z_d    = 1'b0;
                    state_d     = S_RUN;
                end
            end

            S_RUN: begin
                if (early_stop) begin
                    state_d = S_FIX;
                end else begin
                    if (mplier_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end

            S_FIX: begin
                result_lo_d = fix_sum[WIDTH-1:0];
                long_out_d  = long_q;
                if (long_q) begin
                    result_hi_d = fix_sum[2*WIDTH-1:WIDTH];
                    flag_n_d    = fix_sum[2*WIDTH-1];
                    flag_z_d    = (fix_sum == '0);
                end else begin
                    result_hi_d = '0;
                    flag_n_d    = fix_sum[WIDTH-1];
                    flag_z_d    = (fix_sum[WIDTH-1:0] == '0);
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            acc_lo_q    <= '0;
            acc_hi_q    <= '0;
            acc_en_q    <= 1'b0;
            long_q      <= 1'b0;
            result_lo_q <= '0;
            result_hi_q <= '0;
            long_out_q  <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_z_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            acc_lo_q    <= acc_lo_d;
            acc_hi_q    <= acc_hi_d;
            acc_en_q    <= acc_en_d;
            long_q      <= long_d;
            result_lo_q <= result_lo_d;
            result_hi_q <= result_hi_d;
            long_out_q  <= long_out_d;
            flag_n_q    <= flag_n_d;
            flag_z_q    <= flag_z_d;
        end
    end

    // Handshake: start is sampled only in IDLE; done is a one-cycle pulse never overlapping busy.
    assign busy      = (state_q == S_RUN) || (state_q == S_FIX);
    assign done      = (state_q == S_DONE);
    assign result_lo = result_lo_q;
    assign result_hi = result_hi_q;
    assign long_out  = long_out_q;
    assign flag_n    = flag_n_q;
    assign flag_z    = flag_z_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_long_unit.sv
// Self-checking bench for mul_long_unit: directed cases, stall/reset scenarios, random ops vs an arithmetic model.
module tb_mul_long_unit;

  localparam int W = 32;
  localparam int TIMEOUT = 100;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b, acc_lo, acc_hi;
  logic         is_signed, accumulate, long;
  logic         busy, done, long_out, flag_n, flag_z;
  logic [W-1:0] result_lo, result_hi;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  // {long_out, flag_n, flag_z, result_hi, result_lo}
  logic [2*W+2:0] exp_q[$];

  mul_long_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .acc_lo(acc_lo), .acc_hi(acc_hi), .is_signed(is_signed),
    .accumulate(accumulate), .long(long), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .long_out(long_out),
    .flag_n(flag_n), .flag_z(flag_z), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic [W-1:0] alo, input logic [W-1:0] ahi,
                                           input logic sg, input logic ac, input logic lg);
    logic [2*W-1:0] p, ea, eb;
    logic [W-1:0]   hi, lo;
    logic           n, z;
    ea = sg ? {{W{ma[W-1]}}, ma} : {{W{1'b0}}, ma};
    eb = sg ? {{W{mb[W-1]}}, mb} : {{W{1'b0}}, mb};
    p = ea * eb;
    if (ac) p = p + {(lg ? ahi : {W{1'b0}}), alo};
    lo = p[W-1:0];
    hi = lg ? p[2*W-1:W] : '0;
    n  = lg ? hi[W-1] : lo[W-1];
    z  = ({hi, lo} == '0);
    return {lg, n, z, hi, lo};
  endfunction

  function automatic int exp_lat(input logic [W-1:0] mb, input logic sg);
    logic [W-1:0] mag;
    int len;
    mag = (sg && mb[W-1]) ? -mb : mb;
    len = 0;
    for (int i = 0; i < W; i++) if (mag[i]) len = i + 1;
`ifdef MUL_EARLY_TERM_EN
    if (len == 0) return 2;
    return (len + 2 > W + 1) ? W + 1 : len + 2;
`else
    return W + 1;
`endif
  endfunction

  task automatic drive_inputs(input logic [W-1:0] ia, input logic [W-1:0] ib,
                              input logic [W-1:0] ilo, input logic [W-1:0] ihi,
                              input logic sg, input logic ac, input logic lg);
    a = ia; b = ib; acc_lo = ilo; acc_hi = ihi;
    is_signed = sg; accumulate = ac; long = lg;
  endtask

  task automatic scramble_inputs();
    a = $urandom; b = $urandom; acc_lo = $urandom; acc_hi = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    accumulate = 1'($urandom_range(0, 1));
    long = 1'($urandom_range(0, 1));
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ilo, input logic [W-1:0] ihi,
                        input logic sg, input logic ac, input logic lg);
    int cyc, lat;
    bit seq_bad;
    logic [2*W+2:0] exp, got;
    @(negedge clk);
    drive_inputs(ia, ib, ilo, ihi, sg, ac, lg);
    start = 1'b1;
    exp_q.push_back(model(ia, ib, ilo, ihi, sg, ac, lg));
    lat = exp_lat(ib, sg);
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    checks++;
    if (busy !== 1'b1 || result_lo !== '0 || result_hi !== '0 || long_out !== 1'b0 || flag_z !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: busy=%b lo=%h hi=%h long_out=%b z=%b, required busy=1 and cleared results",
               name, busy, result_lo, result_hi, long_out, flag_z);
    end
    cyc = 0;
    seq_bad = 0;
    while (done !== 1'b1 && cyc < TIMEOUT) begin
      @(posedge clk); #1;
      cyc++;
      if (done !== 1'b1 && busy !== 1'b1) seq_bad = 1;
      if (done === 1'b1 && busy !== 1'b0) seq_bad = 1;
    end
    exp = exp_q.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles", name, TIMEOUT);
      return;
    end
    if (cyc != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc, lat);
    end
    checks++;
    if (seq_bad) begin
      errors++;
      $display("FAIL %s busy/done: busy dropped early or overlapped done", name);
    end
    checks++;
    got = {long_out, flag_n, flag_z, result_hi, result_lo};
    if (got !== exp) begin
      errors++;
      $display("FAIL %s result: got long=%b n=%b z=%b hi=%h lo=%h, required long=%b n=%b z=%b hi=%h lo=%h",
               name, got[2*W+2], got[2*W+1], got[2*W], got[2*W-1:W], got[W-1:0],
               exp[2*W+2], exp[2*W+1], exp[2*W], exp[2*W-1:W], exp[W-1:0]);
    end
    @(posedge clk); #1;
    checks++;
    got = {long_out, flag_n, flag_z, result_hi, result_lo};
    if (done !== 1'b0 || busy !== 1'b0 || got !== exp) begin
      errors++;
      $display("FAIL %s hold: done=%b busy=%b lo=%h hi=%h, required done=0 busy=0 lo=%h hi=%h",
               name, done, busy, result_lo, result_hi, exp[W-1:0], exp[2*W-1:W]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    drive_inputs('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result_lo !== '0 || result_hi !== '0 ||
        long_out !== 1'b0 || flag_n !== 1'b0 || flag_z !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b lo=%h hi=%h long=%b n=%b z=%b, required all 0",
               busy, done, result_lo, result_hi, long_out, flag_n, flag_z);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    run_op("umull_max", 32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0, 1'b1 ^ 1'b1, 1'b0, 1'b1);
    run_op("smull_neg", 32'hFFFFFFFE, 32'h00000003, '0, '0, 1'b1, 1'b0, 1'b1);
    run_op("mla_wrap", 32'h00000007, 32'h00000006, 32'hFFFFFFF0, 32'h12345678, 1'b0, 1'b1, 1'b0);
    run_op("umlal_wrap", 32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1);
    run_op("smull_min", 32'h80000000, 32'h80000000, '0, '0, 1'b1, 1'b0, 1'b1);
    run_op("smlal_min", 32'h80000000, 32'h00000001, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b1);
    run_op("mul_b0", 32'h12345678, 32'h00000000, '0, '0, 1'b0, 1'b0, 1'b0);
    run_op("mul_b1", 32'h12345678, 32'h00000001, '0, '0, 1'b0, 1'b0, 1'b0);
    run_op("umull_bmsb", 32'h00000003, 32'h80000000, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_stall_and_reset();
    int cyc;
    logic [2*W+2:0] exp;
    exp = model(32'h12345678, 32'h9ABCDEF0, '0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive_inputs(32'h12345678, 32'h9ABCDEF0, '0, '0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < TIMEOUT) begin
      @(negedge clk);
      if (cyc % 4 == 2) begin
        scramble_inputs();
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (done !== 1'b1 || {result_hi, result_lo} !== exp[2*W-1:0]) begin
      errors++;
      $display("FAIL stall_result: done=%b hi=%h lo=%h, required done=1 hi=%h lo=%h",
               done, result_hi, result_lo, exp[2*W-1:W], exp[W-1:0]);
    end
    // start presented during DONE must not be accepted.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || {result_hi, result_lo} !== exp[2*W-1:0]) begin
      errors++;
      $display("FAIL start_in_done: busy=%b lo=%h, required busy=0 lo=%h", busy, result_lo, exp[W-1:0]);
    end

    @(negedge clk);
    drive_inputs(32'hDEADBEEF, 32'h0000FFFF, '0, '0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result_lo !== '0 || result_hi !== '0 || long_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop: busy=%b done=%b lo=%h hi=%h long=%b, required all 0",
               busy, done, result_lo, result_hi, long_out);
    end
    @(negedge clk);
    reset = 1'b1;
    run_op("after_reset", 32'h00000003, 32'h00000005, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: rb = $urandom_range(0, 3);
        2: rb = rb >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op("random", ra, rb, $urandom, $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_0", 32'h00010000, 32'h00010000, '0, '0, 1'b0, 1'b0, 1'b1);
    run_op("b2b_1", 32'hFFFFFFFF, 32'h00000001, '0, '0, 1'b1, 1'b0, 1'b0);
    run_op("b2b_2", 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_and_reset();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
